// File: rtl/nlc_channel_sequencer_if.sv
// Bundle of every non-clock signal of nlc_channel_sequencer.
//   s_*     : upstream sample stream tagged by channel (valid/ready)
//   cfg_*   : coefficient bank write port
//   nlc_*   : drive and return sides of the linearizer
//   m_*     : downstream result stream (valid/ready)
//   busy/fault/spurious : status
// slave  : the sequencer's view.  master : the environment's view.
interface nlc_channel_sequencer_if;
  logic        s_valid;
  logic        s_ready;
  logic [3:0]  s_ch;
  logic [20:0] s_x_adc;
  logic [20:0] s_x_ref;

  logic        cfg_we;
  logic [3:0]  cfg_ch;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_data;

  logic        nlc_srdyi;
  logic [1:0]  nlc_mode;
  logic [20:0] nlc_x_adc;
  logic [20:0] nlc_x_ref;
  logic [31:0] nlc_coeff_0;
  logic [31:0] nlc_coeff_1;
  logic [31:0] nlc_coeff_2;
  logic [31:0] nlc_coeff_3;
  logic [31:0] nlc_coeff_4;
  logic [31:0] nlc_coeff_5;
  logic [31:0] nlc_neg_mean;
  logic [31:0] nlc_recip_stdev;
  logic        nlc_srdyo;
  logic [20:0] nlc_x_lin;

  logic        m_valid;
  logic        m_ready;
  logic [3:0]  m_ch;
  logic [20:0] m_x_lin;
  logic [21:0] m_err;
  logic        m_timeout;

  logic        busy;
  logic        fault;
  logic        spurious;

  modport slave (
    input  s_valid, s_ch, s_x_adc, s_x_ref,
    output s_ready,
    input  cfg_we, cfg_ch, cfg_addr, cfg_data,
    output nlc_srdyi, nlc_mode, nlc_x_adc, nlc_x_ref,
    output nlc_coeff_0, nlc_coeff_1, nlc_coeff_2, nlc_coeff_3, nlc_coeff_4, nlc_coeff_5,
    output nlc_neg_mean, nlc_recip_stdev,
    input  nlc_srdyo, nlc_x_lin,
    output m_valid, m_ch, m_x_lin, m_err, m_timeout,
    input  m_ready,
    output busy, fault, spurious
  );

  modport master (
    output s_valid, s_ch, s_x_adc, s_x_ref,
    input  s_ready,
    output cfg_we, cfg_ch, cfg_addr, cfg_data,
    input  nlc_srdyi, nlc_mode, nlc_x_adc, nlc_x_ref,
    input  nlc_coeff_0, nlc_coeff_1, nlc_coeff_2, nlc_coeff_3, nlc_coeff_4, nlc_coeff_5,
    input  nlc_neg_mean, nlc_recip_stdev,
    output nlc_srdyo, nlc_x_lin,
    input  m_valid, m_ch, m_x_lin, m_err, m_timeout,
    output m_ready,
    input  busy, fault, spurious
  );
endinterface

// File: rtl/nlc_channel_sequencer.sv
// nlc_channel_sequencer: feeds one channel-tagged sample at a time into a
// nonlinearity-correction linearizer and returns the corrected result.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : nlc_channel_sequencer_if.slave (sample in, cfg write, linearizer
//           drive/return, result out, status)
// A 16x8x32 coefficient bank is written through cfg_*. On accept, the sample
// and its channel's 8 words are frozen into a snapshot that drives the
// linearizer until the next accept. A result (or a timeout) is held on m_*
// until taken; a timeout result parks the block in FAULT until reset.
module nlc_channel_sequencer #(
  parameter int TIMEOUT = 255
) (
  input logic                    clk,
  input logic                    reset,
  nlc_channel_sequencer_if.slave bus
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, FAULT} state_t;

  state_t      state_q;

  // coefficient bank
  logic [31:0] bank_q [16][8];
  logic [15:0] loaded_q;

  // snapshot taken at accept
  logic [3:0]  snap_ch_q;
  logic [20:0] snap_adc_q;
  logic [20:0] snap_ref_q;
  logic [31:0] snap_w_q [8];
  logic        snap_loaded_q;

  logic [CW-1:0] cnt_q;

  // registered outputs
  logic        s_ready_q;
  logic        srdyi_q;
  logic        m_valid_q;
  logic        m_timeout_q;
  logic [20:0] m_x_lin_q;
  logic [21:0] m_err_q;
  logic        busy_q;
  logic        fault_q;
  logic        spurious_q;

  logic [21:0] m_err_d;

  // Unsigned operands widened by one bit so the difference is a proper
  // 22-bit two's complement error.
  assign m_err_d = {1'b0, bus.nlc_x_lin} - {1'b0, snap_ref_q};

  // ---------------------------------------------------------------- bank
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 16; c++)
        for (int w = 0; w < 8; w++)
          bank_q[c][w] <= '0;
      loaded_q <= '0;
    end else if (bus.cfg_we) begin
      bank_q[bus.cfg_ch][bus.cfg_addr] <= bus.cfg_data;
      // recip_stdev is the last word of a full load
      if (bus.cfg_addr == 3'd7) loaded_q[bus.cfg_ch] <= 1'b1;
    end
  end

  // ----------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      snap_ch_q     <= '0;
      snap_adc_q    <= '0;
      snap_ref_q    <= '0;
      for (int w = 0; w < 8; w++) snap_w_q[w] <= '0;
      snap_loaded_q <= 1'b0;
      cnt_q         <= '0;
      s_ready_q     <= 1'b1;
      srdyi_q       <= 1'b0;
      m_valid_q     <= 1'b0;
      m_timeout_q   <= 1'b0;
      m_x_lin_q     <= '0;
      m_err_q       <= '0;
      busy_q        <= 1'b0;
      fault_q       <= 1'b0;
      spurious_q    <= 1'b0;
    end else begin
      // a return strobe outside WAIT has no sample to belong to
      if (bus.nlc_srdyo && state_q != WAIT) spurious_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (bus.s_valid) begin
            // bank_q is read before any same-edge cfg write lands
            snap_ch_q     <= bus.s_ch;
            snap_adc_q    <= bus.s_x_adc;
            snap_ref_q    <= bus.s_x_ref;
            for (int w = 0; w < 8; w++) snap_w_q[w] <= bank_q[bus.s_ch][w];
            snap_loaded_q <= loaded_q[bus.s_ch];
            state_q       <= ISSUE;
            s_ready_q     <= 1'b0;
            srdyi_q       <= 1'b1;
            busy_q        <= 1'b1;
          end
        end

        ISSUE: begin
          state_q <= WAIT;
          srdyi_q <= 1'b0;
          cnt_q   <= '0;
        end

        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          // a response in the final counted cycle still wins over timeout
          if (bus.nlc_srdyo) begin
            m_x_lin_q   <= bus.nlc_x_lin;
            m_err_q     <= m_err_d;
            m_timeout_q <= 1'b0;
            m_valid_q   <= 1'b1;
            state_q     <= HOLD;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            m_x_lin_q   <= '0;
            m_err_q     <= '0;
            m_timeout_q <= 1'b1;
            m_valid_q   <= 1'b1;
            state_q     <= HOLD;
          end
        end

        HOLD: begin
          if (bus.m_ready) begin
            m_valid_q <= 1'b0;
            if (m_timeout_q) begin
              state_q <= FAULT;
              fault_q <= 1'b1;
            end else begin
              state_q   <= IDLE;
              s_ready_q <= 1'b1;
              busy_q    <= 1'b0;
            end
          end
        end

        FAULT: ; // sticky until reset

        default: begin
          state_q   <= IDLE;
          s_ready_q <= 1'b1;
          srdyi_q   <= 1'b0;
          m_valid_q <= 1'b0;
          busy_q    <= 1'b0;
          fault_q   <= 1'b0;
        end
      endcase
    end
  end

  // ------------------------------------------------------------- outputs
  assign bus.s_ready         = s_ready_q;
  assign bus.nlc_srdyi       = srdyi_q;
  // unloaded channel: linearizer falls back on its stored coefficients
  assign bus.nlc_mode        = snap_loaded_q ? 2'b00 : 2'b11;
  assign bus.nlc_x_adc       = snap_adc_q;
  assign bus.nlc_x_ref       = snap_ref_q;
  assign bus.nlc_coeff_0     = snap_w_q[0];
  assign bus.nlc_coeff_1     = snap_w_q[1];
  assign bus.nlc_coeff_2     = snap_w_q[2];
  assign bus.nlc_coeff_3     = snap_w_q[3];
  assign bus.nlc_coeff_4     = snap_w_q[4];
  assign bus.nlc_coeff_5     = snap_w_q[5];
  assign bus.nlc_neg_mean    = snap_w_q[6];
  assign bus.nlc_recip_stdev = snap_w_q[7];
  assign bus.m_valid         = m_valid_q;
  assign bus.m_ch            = snap_ch_q;
  assign bus.m_x_lin         = m_x_lin_q;
  assign bus.m_err           = m_err_q;
  assign bus.m_timeout       = m_timeout_q;
  assign bus.busy            = busy_q;
  assign bus.fault           = fault_q;
  assign bus.spurious        = spurious_q;

endmodule

// File: tb/tb_nlc_channel_sequencer.sv
// Testbench for nlc_channel_sequencer: a linearizer model answers srdyi after
// a programmable delay; expected results are queued at stimulus time and
// popped when m_valid appears. A second instance with TIMEOUT=16 and a silent
// linearizer covers the timeout/fault path.
module tb_nlc_channel_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rst_t = 1'b1;
  always #5 clk = ~clk;

  nlc_channel_sequencer_if bus();
  nlc_channel_sequencer_if bus_t();

  nlc_channel_sequencer #(.TIMEOUT(255)) dut   (.clk(clk), .reset(reset), .bus(bus));
  nlc_channel_sequencer #(.TIMEOUT(16))  dut_t (.clk(clk), .reset(rst_t), .bus(bus_t));

  typedef struct {
    logic [3:0]  ch;
    logic [20:0] xlin;
    logic [21:0] err;
    logic        tmo;
  } exp_t;

  typedef struct {
    logic [3:0]  ch;
    logic [20:0] adc;
    logic [20:0] xr;
    logic [20:0] xlin;
    int          dly;
    logic [21:0] err;
  } vec_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int srdyi_cnt = 0;
  int pulse_base = 0;
  int srdyo_cyc = 0;

  logic [31:0] bank_m [16][8];
  logic [15:0] loaded_m;

  // linearizer model controls
  int          model_dly = 1;
  logic [20:0] model_val = '0;
  bit          model_abort = 1'b0;
  logic        mdl_srdyo;
  logic [20:0] mdl_x_lin;
  logic        tb_srdyo = 1'b0;

  assign bus.nlc_srdyo   = mdl_srdyo | tb_srdyo;
  assign bus.nlc_x_lin   = mdl_x_lin;
  assign bus_t.nlc_srdyo = 1'b0;
  assign bus_t.nlc_x_lin = '0;
  assign bus_t.cfg_we    = 1'b0;
  assign bus_t.cfg_ch    = '0;
  assign bus_t.cfg_addr  = '0;
  assign bus_t.cfg_data  = '0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.nlc_srdyi === 1'b1) srdyi_cnt <= srdyi_cnt + 1;

  // linearizer model: answers model_dly cycles after the srdyi cycle
  initial begin
    bit aborted;
    mdl_srdyo = 1'b0;
    mdl_x_lin = '0;
    forever begin
      @(negedge clk);
      if (bus.nlc_srdyi === 1'b1) begin
        aborted = 1'b0;
        for (int i = 0; i < model_dly; i++) begin
          @(posedge clk);
          if (model_abort) begin aborted = 1'b1; break; end
        end
        if (!aborted) begin
          #1;
          mdl_x_lin = model_val;
          mdl_srdyo = 1'b1;
          srdyo_cyc = cyc;
          @(posedge clk);
          #1 mdl_srdyo = 1'b0;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [3:0] ch, input logic [2:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    bus.cfg_we = 1'b1; bus.cfg_ch = ch; bus.cfg_addr = addr; bus.cfg_data = data;
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    bank_m[ch][addr] = data;
    if (addr == 3'd7) loaded_m[ch] = 1'b1;
  endtask

  task automatic send(input logic [3:0] ch, input logic [20:0] adc, input logic [20:0] xr,
                      input logic [20:0] xlin, input logic [21:0] exp_err);
    exp_t e;
    bit ok;
    @(posedge clk); #1;
    pulse_base = srdyi_cnt;
    bus.s_valid = 1'b1; bus.s_ch = ch; bus.s_x_adc = adc; bus.s_x_ref = xr;
    model_val = xlin;
    e.ch = ch; e.xlin = xlin; e.err = exp_err; e.tmo = 1'b0;
    sb.push_back(e);
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.s_ready === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) chk("s_ready_wait", 64'd0, 64'd1);
    @(posedge clk); #1 bus.s_valid = 1'b0;
    @(negedge clk);
    chk("srdyi_issue", bus.nlc_srdyi, 1);
    chk("nlc_mode", bus.nlc_mode, loaded_m[ch] ? 2'b00 : 2'b11);
    chk("nlc_coeff_0", bus.nlc_coeff_0, bank_m[ch][0]);
    chk("nlc_recip_stdev", bus.nlc_recip_stdev, bank_m[ch][7]);
    chk("nlc_x_adc", bus.nlc_x_adc, adc);
    chk("nlc_x_ref", bus.nlc_x_ref, xr);
  endtask

  task automatic wait_result(input int hold, input bit spur);
    exp_t e;
    bit ok;
    bit stable;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (bus.m_valid === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) begin chk("m_valid_wait", 64'd0, 64'd1); return; end
    if (sb.size() == 0) begin chk("scoreboard_empty", 64'd0, 64'd1); return; end
    e = sb.pop_front();
    chk("out_latency", cyc, srdyo_cyc + 1);
    chk("m_ch", bus.m_ch, e.ch);
    chk("m_x_lin", bus.m_x_lin, e.xlin);
    chk("m_err", bus.m_err, e.err);
    chk("m_timeout", bus.m_timeout, e.tmo);
    chk("srdyi_pulses", srdyi_cnt - pulse_base, 1);
    chk("s_ready_in_hold", bus.s_ready, 0);
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      tb_srdyo = (spur && h == 3);
      @(negedge clk);
      if (bus.m_valid !== 1'b1 || bus.m_ch !== e.ch || bus.m_x_lin !== e.xlin ||
          bus.m_err !== e.err || bus.s_ready !== 1'b0) stable = 1'b0;
    end
    tb_srdyo = 1'b0;
    if (hold > 0) chk("hold_stable", stable, 1);
    if (spur) chk("spurious_set", bus.spurious, 1);
    bus.m_ready = 1'b1;
    @(posedge clk); #1 bus.m_ready = 1'b0;
    @(negedge clk);
    chk("m_valid_drop", bus.m_valid, 0);
    chk("s_ready_back", bus.s_ready, 1);
  endtask

  initial begin
    vec_t vt[5];
    exp_t e;
    int   n;
    bit   found;
    bit   sticky;

    bus.s_valid = 1'b0; bus.s_ch = '0; bus.s_x_adc = '0; bus.s_x_ref = '0;
    bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.m_ready = 1'b0;
    bus_t.s_valid = 1'b0; bus_t.s_ch = '0; bus_t.s_x_adc = '0; bus_t.s_x_ref = '0;
    bus_t.m_ready = 1'b0;
    for (int c = 0; c < 16; c++) for (int w = 0; w < 8; w++) bank_m[c][w] = '0;
    loaded_m = '0;

    vt[0] = '{4'd3,  21'h01000,  21'h01010,  21'h01008,  40, 22'h3FFFF8};
    vt[1] = '{4'd5,  21'h00123,  21'h00100,  21'h00110,  3,  22'h000010};
    vt[2] = '{4'd0,  21'h1FFFFF, 21'h000000, 21'h1FFFFF, 1,  22'h1FFFFF};
    vt[3] = '{4'd15, 21'h000000, 21'h1FFFFF, 21'h000000, 2,  22'h200001};
    vt[4] = '{4'd3,  21'h0ABCD,  21'h0ABCD,  21'h0ABCD,  5,  22'h000000};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0; rst_t = 1'b0;
    @(negedge clk);
    chk("rst_s_ready", bus.s_ready, 1);
    chk("rst_srdyi", bus.nlc_srdyi, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_timeout", bus.m_timeout, 0);
    chk("rst_spurious", bus.spurious, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_fault", bus.fault, 0);
    chk("rst_mode", bus.nlc_mode, 2'b11);
    chk("rst_m_err", bus.m_err, 0);

    // load channel 5 fully, channel 15 partially (stays unloaded)
    cfg_write(4'd5, 3'd0, 32'hC4694000);
    for (int a = 1; a < 6; a++) cfg_write(4'd5, 3'(a), 32'h11111111 * a);
    cfg_write(4'd5, 3'd6, 32'hBF800000);
    cfg_write(4'd5, 3'd7, 32'h36F2A140);
    cfg_write(4'd15, 3'd0, 32'hDEADBEEF);

    // vector table
    for (int i = 0; i < 5; i++) begin
      model_dly = vt[i].dly;
      send(vt[i].ch, vt[i].adc, vt[i].xr, vt[i].xlin, vt[i].err);
      wait_result(0, 1'b0);
    end
    chk("no_spurious", bus.spurious, 0);

    // bank rewrite during WAIT does not reach the snapshot
    model_dly = 20;
    send(4'd5, 21'h00200, 21'h00300, 21'h00280, 22'h3FFF80);
    cfg_write(4'd5, 3'd0, 32'h12345678);
    @(negedge clk);
    chk("coeff0_frozen", bus.nlc_coeff_0, 32'hC4694000);
    wait_result(0, 1'b0);
    model_dly = 4;
    send(4'd5, 21'h00010, 21'h00008, 21'h00009, 22'h000001);
    chk("coeff0_new", bus.nlc_coeff_0, 32'h12345678);
    wait_result(0, 1'b0);

    // long HOLD with a stray return strobe
    model_dly = 2;
    send(4'd5, 21'h00400, 21'h00400, 21'h00401, 22'h000001);
    wait_result(10, 1'b1);

    // reset mid-WAIT
    model_dly = 30;
    send(4'd3, 21'h00050, 21'h00060, 21'h00055, 22'h3FFFF5);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1; model_abort = 1'b1;
    #1;
    chk("arst_s_ready", bus.s_ready, 1);
    chk("arst_busy", bus.busy, 0);
    chk("arst_srdyi", bus.nlc_srdyi, 0);
    chk("arst_m_valid", bus.m_valid, 0);
    chk("arst_spurious", bus.spurious, 0);
    chk("arst_mode", bus.nlc_mode, 2'b11);
    chk("arst_coeff0", bus.nlc_coeff_0, 0);
    chk("arst_m_x_lin", bus.m_x_lin, 0);
    chk("arst_m_ch", bus.m_ch, 0);
    sb.delete();
    for (int c = 0; c < 16; c++) for (int w = 0; w < 8; w++) bank_m[c][w] = '0;
    loaded_m = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0; model_abort = 1'b0;
    model_dly = 4;
    send(4'd5, 21'h00700, 21'h00600, 21'h00650, 22'h000050);
    wait_result(0, 1'b0);

    // timeout path on the TIMEOUT=16 instance
    @(posedge clk); #1;
    bus_t.s_valid = 1'b1; bus_t.s_ch = 4'd7; bus_t.s_x_adc = 21'h00005; bus_t.s_x_ref = 21'h00100;
    e.ch = 4'd7; e.xlin = '0; e.err = '0; e.tmo = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    chk("t_s_ready", bus_t.s_ready, 1);
    @(posedge clk); #1 bus_t.s_valid = 1'b0;
    n = 0; found = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      if (bus_t.m_valid === 1'b1) begin n = k; found = 1'b1; break; end
    end
    chk("t_m_valid_seen", found, 1);
    chk("t_latency", n, 17);
    e = sb.pop_front();
    chk("t_m_timeout", bus_t.m_timeout, e.tmo);
    chk("t_m_x_lin", bus_t.m_x_lin, e.xlin);
    chk("t_m_err", bus_t.m_err, e.err);
    chk("t_m_ch", bus_t.m_ch, e.ch);
    chk("t_fault_before", bus_t.fault, 0);
    bus_t.m_ready = 1'b1;
    @(posedge clk); #1 bus_t.m_ready = 1'b0; bus_t.s_valid = 1'b1;
    @(negedge clk);
    chk("t_fault", bus_t.fault, 1);
    chk("t_s_ready_fault", bus_t.s_ready, 0);
    chk("t_m_valid_fault", bus_t.m_valid, 0);
    chk("t_busy_fault", bus_t.busy, 1);
    sticky = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus_t.fault !== 1'b1 || bus_t.s_ready !== 1'b0 || bus_t.nlc_srdyi !== 1'b0) sticky = 1'b0;
    end
    chk("t_fault_sticky", sticky, 1);
    rst_t = 1'b1;
    #1;
    chk("t_fault_cleared", bus_t.fault, 0);
    chk("t_s_ready_cleared", bus_t.s_ready, 1);
    bus_t.s_valid = 1'b0;
    @(negedge clk); rst_t = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nlc_channel_sequencer.md
NLC_CHANNEL_SEQUENCER -- requirements
Module: nlc_channel_sequencer

Interface
REQ-001 Parameter: TIMEOUT, default 255, max WAIT cycles before a sample is declared lost.
REQ-002 Ports: clk  in  1  system clock, all logic on rising edge.
REQ-003 Ports: reset  in  1  asynchronous, active-high reset.
REQ-004 Ports: s_valid in 1, s_ready out 1, s_ch in 4, s_x_adc in 21, s_x_ref in 21: upstream sample stream, tagged by channel.
REQ-005 Ports: cfg_we in 1, cfg_ch in 4, cfg_addr in 3, cfg_data in 32: coefficient bank write; addr 0-5 = coeff_0..coeff_5, 6 = neg_mean, 7 = recip_stdev.
REQ-006 Ports: nlc_srdyi out 1, nlc_mode out 2, nlc_x_adc out 21, nlc_x_ref out 21, nlc_coeff_0..nlc_coeff_5 out 32 each, nlc_neg_mean out 32, nlc_recip_stdev out 32: drive side of the linearizer.
REQ-007 Ports: nlc_srdyo in 1, nlc_x_lin in 21: return side of the linearizer.
REQ-008 Ports: m_valid out 1, m_ready in 1, m_ch out 4, m_x_lin out 21, m_err out 22, m_timeout out 1: downstream result stream.
REQ-009 Ports: busy out 1 (state != IDLE), fault out 1 (state == FAULT), spurious out 1 (sticky unexpected nlc_srdyo).

Function
REQ-010 Coefficient bank: 16 channels x 8 words x 32 bits; a cfg_we cycle writes cfg_data to word [cfg_ch][cfg_addr] at the clock edge.
REQ-011 A write with cfg_addr = 7 additionally sets loaded[cfg_ch]; loaded bits clear only on reset.
REQ-012 States: IDLE, ISSUE, WAIT, HOLD, FAULT.
REQ-013 IDLE: s_ready = 1; on s_valid, capture s_ch, s_x_adc, s_x_ref, all 8 bank words of s_ch and loaded[s_ch] into a snapshot; next state ISSUE.
REQ-014 s_ready = 0 in every state other than IDLE.
REQ-015 ISSUE: nlc_srdyi = 1 for exactly this one cycle; next state WAIT; WAIT counter cleared to 0.
REQ-016 nlc_x_adc, nlc_x_ref, nlc_coeff_*, nlc_neg_mean, nlc_recip_stdev are driven from the snapshot and held stable from ISSUE until the next capture.
REQ-017 nlc_mode = 2'b00 if the snapshot loaded bit is 1, else 2'b11 (linearizer uses its stored coefficients).
REQ-018 Writes to the bank after capture do not alter the snapshot or the outputs of REQ-016; a write in the same cycle as capture is not visible in that snapshot.
REQ-019 WAIT: counter increments each cycle; on nlc_srdyo = 1, register nlc_x_lin into m_x_lin, m_timeout = 0, next state HOLD.
REQ-020 WAIT: if the counter reaches TIMEOUT with nlc_srdyo = 0, m_x_lin = 0, m_timeout = 1, next state HOLD; nlc_srdyo in that same cycle takes priority (normal completion).
REQ-021 m_err = {1'b0, m_x_lin} - {1'b0, snapshot x_ref}, 22-bit two's complement, registered with m_x_lin; m_err = 0 when m_timeout = 1.
REQ-022 HOLD: m_valid = 1, m_ch = snapshot channel; m_* stable while m_valid & !m_ready.
REQ-023 HOLD with m_ready = 1: next state IDLE, or FAULT if m_timeout = 1.
REQ-024 FAULT: s_ready = 0, nlc_srdyi = 0, m_valid = 0; exit only by reset.
REQ-025 nlc_srdyo = 1 in IDLE, ISSUE, HOLD or FAULT sets spurious; data is discarded, state unaffected.
REQ-026 Latency: s handshake at edge k -> nlc_srdyi high cycle k+1; nlc_srdyo high in cycle j -> m_valid high from cycle j+1.
REQ-027 Exactly one sample in flight; no second nlc_srdyi before nlc_srdyo or timeout of the first.

Reset
REQ-028 Asserting reset, at any time including mid-WAIT, forces IDLE asynchronously; after reset s_ready = 1, nlc_srdyi = 0, m_valid = 0, m_timeout = 0, spurious = 0, busy = 0, fault = 0.
REQ-029 Reset clears all bank words, loaded bits, snapshot, WAIT counter, m_x_lin, m_err and m_ch to 0; nlc_mode resets to 2'b11.

Verification
REQ-030 Unloaded channel 3, x_adc = 0x01000, x_ref = 0x01010; model returns x_lin = 0x01008 after 40 cycles -> one srdyi pulse, nlc_mode = 11, m_ch = 3, m_x_lin = 0x01008, m_err = -8.
REQ-031 Write 8 words to channel 5 (coeff_0 = 0xC4694000, recip_stdev = 0x36F2A140), send sample on channel 5 -> nlc_mode = 00, nlc_coeff_0 and nlc_recip_stdev match during the srdyi cycle.
REQ-032 Rewrite channel 5 coeff_0 during WAIT -> nlc_coeff_0 unchanged until next capture; next channel-5 sample carries the new value.
REQ-033 TIMEOUT = 16, model never responds -> m_valid at cycle 16 of WAIT, m_timeout = 1, m_x_lin = 0; after m_ready, fault = 1, s_ready = 0 until reset.
REQ-034 m_ready held low 10 cycles in HOLD -> m_* stable, s_ready = 0; nlc_srdyo pulse in HOLD sets spurious only.
REQ-035 Reset asserted mid-WAIT, then new sample -> outputs match REQ-028/029 immediately; new sample completes normally with a single srdyi pulse.
